// File: rtl/dnf_pkg.sv
// Shared types and constants for the SPI command decoder and its register file.
// Header words are fixed at 16 bits: [15:12] opcode, [11:8] address, [7:0] count.
package dnf_pkg;

    localparam int HDR_W    = 16;
    localparam int OP_LSB   = 12;
    localparam int OP_W     = 4;
    localparam int ADDR_LSB = 8;
    localparam int ADDR_W   = 4;
    localparam int CNT_LSB  = 0;
    localparam int CNT_W    = 8;

    typedef enum logic [OP_W-1:0] {
        OP_STREAM = 4'h1,
        OP_WRITE  = 4'h2,
        OP_READ   = 4'h3
    } opcode_e;

    localparam logic [ADDR_W-1:0] REG_ALPHA  = 4'd0;
    localparam logic [ADDR_W-1:0] REG_CTRL   = 4'd1;
    localparam logic [ADDR_W-1:0] REG_CNT    = 4'd2;
    localparam logic [ADDR_W-1:0] REG_STATUS = 4'd3;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        STREAM,
        WR_DATA,
        DRAIN
    } state_e;

    typedef struct packed {
        logic [OP_W-1:0]   opcode;
        logic [ADDR_W-1:0] addr;
        logic [CNT_W-1:0]  count;
    } header_t;

    function automatic header_t decode_header(input logic [HDR_W-1:0] word);
        header_t h;
        h.opcode = word[OP_LSB +: OP_W];
        h.addr   = word[ADDR_LSB +: ADDR_W];
        h.count  = word[CNT_LSB +: CNT_W];
        return h;
    endfunction

endpackage

// File: rtl/dnf_reg_file.sv
// Control register file: alpha, ctrl, sample counter and sticky error status.
// Reads and writes both land one cycle after the request strobe.
module dnf_reg_file
    import dnf_pkg::*;
#(
    parameter int                DATA_W      = 16,
    parameter logic [DATA_W-1:0] ALPHA_RESET = 16'sd8192,
    parameter logic [DATA_W-1:0] CTRL_RESET  = 16'h0002
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              sample_inc,
    input  logic              err_set,
    output logic [DATA_W-1:0] alpha,
    output logic              bypass,
    output logic              filt_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              err
);

    localparam int N_REGS = 1 << ADDR_W;

    logic [DATA_W-1:0] alpha_reg;
    logic [1:0]        ctrl_reg;
    logic [DATA_W-1:0] cnt_reg;
    logic              err_reg;
    logic [DATA_W-1:0] rd_data_reg;
    logic              rd_valid_reg;

    logic              wr_alpha;
    logic              wr_ctrl;
    logic              wr_bad;
    logic              rd_status;
    logic [DATA_W-1:0] rd_vec [N_REGS];

    assign wr_alpha  = wr_en && (wr_addr == REG_ALPHA);
    assign wr_ctrl   = wr_en && (wr_addr == REG_CTRL);
    // Unmapped addresses flag an error; read-only registers silently ignore writes.
    assign wr_bad    = wr_en && (wr_addr > REG_STATUS);
    assign rd_status = rd_en && (rd_addr == REG_STATUS);

    genvar gi;
    generate
        for (gi = 0; gi < N_REGS; gi++) begin : g_rd
            if (gi == int'(REG_ALPHA)) begin : g_alpha
                assign rd_vec[gi] = alpha_reg;
            end else if (gi == int'(REG_CTRL)) begin : g_ctrl
                assign rd_vec[gi] = {{(DATA_W-2){1'b0}}, ctrl_reg};
            end else if (gi == int'(REG_CNT)) begin : g_cnt
                assign rd_vec[gi] = cnt_reg;
            end else if (gi == int'(REG_STATUS)) begin : g_status
                assign rd_vec[gi] = {{(DATA_W-1){1'b0}}, err_reg};
            end else begin : g_zero
                assign rd_vec[gi] = '0;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alpha_reg    <= ALPHA_RESET;
            ctrl_reg     <= CTRL_RESET[1:0];
            cnt_reg      <= '0;
            err_reg      <= 1'b0;
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            if (wr_alpha) begin
                alpha_reg <= wr_data;
            end
            if (wr_ctrl) begin
                ctrl_reg <= wr_data[1:0];
            end
            if (sample_inc) begin
                cnt_reg <= cnt_reg + DATA_W'(1);
            end
            // Status read returns the pre-clear value and clears in the same edge.
            if (err_set || wr_bad) begin
                err_reg <= 1'b1;
            end else if (rd_status) begin
                err_reg <= 1'b0;
            end
            rd_valid_reg <= rd_en;
            if (rd_en) begin
                rd_data_reg <= rd_vec[rd_addr];
            end
        end
    end

    assign alpha    = alpha_reg;
    assign bypass   = ctrl_reg[0];
    assign filt_en  = ctrl_reg[1];
    assign rd_data  = rd_data_reg;
    assign rd_valid = rd_valid_reg;
    assign err      = err_reg;

endmodule

// File: rtl/spi_cmd_decoder.sv
// Frame parser between the SPI word receiver and the noise filter: a header word
// selects sample streaming or a register read/write; chip-select release ends any frame.
module spi_cmd_decoder
    import dnf_pkg::*;
#(
    parameter int                DATA_W      = 16,
    parameter logic [DATA_W-1:0] ALPHA_RESET = 16'sd8192,
    parameter logic [DATA_W-1:0] CTRL_RESET  = 16'h0002
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sel_n,
    input  logic [DATA_W-1:0]        word_in,
    input  logic                     word_valid,
    output logic [DATA_W-1:0]        x_out,
    output logic                     x_valid,
    output logic signed [DATA_W-1:0] alpha,
    output logic                     bypass,
    output logic                     filt_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic                     err
);

    state_e            state_reg, state_next;
    logic [CNT_W-1:0]  remaining_reg, remaining_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] x_out_reg, x_out_next;
    logic              x_valid_reg, x_valid_next;

    header_t           hdr;
    logic              wr_en;
    logic              rd_en;
    logic              err_set;
    logic              sample_inc;
    logic [DATA_W-1:0] alpha_w;

    assign hdr = decode_header(word_in[HDR_W-1:0]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            remaining_reg <= '0;
            addr_reg      <= '0;
            x_out_reg     <= '0;
            x_valid_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            remaining_reg <= remaining_next;
            addr_reg      <= addr_next;
            x_out_reg     <= x_out_next;
            x_valid_reg   <= x_valid_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        addr_next      = addr_reg;
        x_out_next     = x_out_reg;
        x_valid_next   = 1'b0;
        wr_en          = 1'b0;
        rd_en          = 1'b0;
        err_set        = 1'b0;
        sample_inc     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (!sel_n) begin
                    state_next = HDR;
                end
            end
            HDR: begin
                if (word_valid) begin
                    case (hdr.opcode)
                        OP_STREAM: begin
                            remaining_next = hdr.count;
                            state_next     = STREAM;
                        end
                        OP_WRITE: begin
                            addr_next  = hdr.addr;
                            state_next = WR_DATA;
                        end
                        OP_READ: begin
                            rd_en      = 1'b1;
                            state_next = DRAIN;
                        end
                        default: begin
                            err_set    = 1'b1;
                            state_next = DRAIN;
                        end
                    endcase
                end
            end
            STREAM: begin
                if (word_valid) begin
                    x_out_next   = word_in;
                    x_valid_next = 1'b1;
                    sample_inc   = 1'b1;
                    // A zero count means stream until chip select releases.
                    if (remaining_reg != '0) begin
                        remaining_next = remaining_reg - CNT_W'(1);
                        if (remaining_reg == CNT_W'(1)) begin
                            state_next = DRAIN;
                        end
                    end
                end
            end
            WR_DATA: begin
                if (word_valid) begin
                    wr_en      = 1'b1;
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                state_next = DRAIN;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // The word in this cycle is still honoured above; only the next state is overridden.
        if (sel_n) begin
            state_next     = IDLE;
            remaining_next = '0;
        end
    end

    dnf_reg_file #(
        .DATA_W      (DATA_W),
        .ALPHA_RESET (ALPHA_RESET),
        .CTRL_RESET  (CTRL_RESET)
    ) u_reg_file (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (addr_reg),
        .wr_data    (word_in),
        .rd_en      (rd_en),
        .rd_addr    (hdr.addr),
        .sample_inc (sample_inc),
        .err_set    (err_set),
        .alpha      (alpha_w),
        .bypass     (bypass),
        .filt_en    (filt_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .err        (err)
    );

    assign alpha   = $signed(alpha_w);
    assign x_out   = x_out_reg;
    assign x_valid = x_valid_reg;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Scoreboard bench for spi_cmd_decoder: frames are scored by a frame-level model,
// and a negedge monitor checks every x_valid / rd_valid / register update.
module tb_spi_cmd_decoder;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               sel_n = 1'b1;
    logic [15:0]        word_in = '0;
    logic               word_valid = 1'b0;
    logic [15:0]        x_out;
    logic               x_valid;
    logic signed [15:0] alpha;
    logic               bypass;
    logic               filt_en;
    logic [15:0]        rd_data;
    logic               rd_valid;
    logic               err;

    spi_cmd_decoder dut (
        .clk        (clk),
        .reset      (reset),
        .sel_n      (sel_n),
        .word_in    (word_in),
        .word_valid (word_valid),
        .x_out      (x_out),
        .x_valid    (x_valid),
        .alpha      (alpha),
        .bypass     (bypass),
        .filt_en    (filt_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .err        (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    typedef struct {
        int          cyc;
        logic [15:0] alpha;
        logic [1:0]  ctrl;
    } wexp_t;

    exp_t        exp_x[$];
    exp_t        exp_rd[$];
    wexp_t       exp_w[$];
    logic [15:0] frame_q[$];

    // Reference register state
    logic [15:0] alpha_m = 16'd8192;
    logic [1:0]  ctrl_m  = 2'b10;
    logic [15:0] cnt_m   = '0;
    logic        err_m   = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] read_m(input logic [3:0] addr);
        case (addr)
            4'd0:    return alpha_m;
            4'd1:    return {14'b0, ctrl_m};
            4'd2:    return cnt_m;
            4'd3:    return {15'b0, err_m};
            default: return 16'h0000;
        endcase
    endfunction

    // Monitor: pops expectations whenever the DUT presents an output.
    always @(negedge clk) begin
        exp_t  e;
        wexp_t w;
        if (reset && x_valid) begin
            if (exp_x.size() == 0) begin
                chk("x_unexpected", x_out, 16'hxxxx);
            end else begin
                e = exp_x.pop_front();
                $display("[TB] x_valid data=%h cyc=%0d", x_out, cyc);
                chk("x_data", x_out, e.data);
                chk("x_latency", 16'(cyc), 16'(e.cyc));
            end
        end
        if (reset && rd_valid) begin
            if (exp_rd.size() == 0) begin
                chk("rd_unexpected", rd_data, 16'hxxxx);
            end else begin
                e = exp_rd.pop_front();
                $display("[TB] rd_valid data=%h cyc=%0d", rd_data, cyc);
                chk("rd_data", rd_data, e.data);
                chk("rd_latency", 16'(cyc), 16'(e.cyc));
            end
        end
        if (exp_w.size() > 0 && exp_w[0].cyc <= cyc) begin
            w = exp_w.pop_front();
            $display("[TB] reg write alpha=%h ctrl=%b cyc=%0d", alpha, {filt_en, bypass}, cyc);
            chk("wr_alpha", alpha, w.alpha);
            chk("wr_ctrl", {14'b0, filt_en, bypass}, {14'b0, w.ctrl});
        end
    end

    // Drives frame_q as one chip-select frame and records what the model expects.
    task automatic send_frame(input bit close_same);
        int          n;
        int          fwd;
        logic [15:0] w;
        logic [3:0]  op;
        logic [3:0]  addr;
        logic [7:0]  cntf;
        n    = frame_q.size();
        op   = frame_q[0][15:12];
        addr = frame_q[0][11:8];
        cntf = frame_q[0][7:0];
        fwd  = 0;
        @(posedge clk); #1 sel_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1 word_valid = 1'b0;
            if (i > 0) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
            end
            w          = frame_q[i];
            word_in    = w;
            word_valid = 1'b1;
            if (close_same && i == n - 1) sel_n = 1'b1;
            if (i == 0) begin
                if (op == 4'd3) begin
                    exp_rd.push_back('{read_m(addr), cyc + 1});
                    if (addr == 4'd3) err_m = 1'b0;
                end else if (op != 4'd1 && op != 4'd2) begin
                    err_m = 1'b1;
                end
            end else if (op == 4'd1) begin
                if (cntf == 0 || fwd < int'(cntf)) begin
                    exp_x.push_back('{w, cyc + 1});
                    cnt_m = cnt_m + 16'd1;
                    fwd++;
                end
            end else if (op == 4'd2 && i == 1) begin
                if (addr == 4'd0) alpha_m = w;
                else if (addr == 4'd1) ctrl_m = w[1:0];
                else if (addr > 4'd3) err_m = 1'b1;
                exp_w.push_back('{cyc + 1, alpha_m, ctrl_m});
            end
        end
        @(posedge clk); #1 word_valid = 1'b0; sel_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_static();
        @(negedge clk);
        chk("alpha", alpha, alpha_m);
        chk("bypass", {15'b0, bypass}, {15'b0, ctrl_m[0]});
        chk("filt_en", {15'b0, filt_en}, {15'b0, ctrl_m[1]});
        chk("err", {15'b0, err}, {15'b0, err_m});
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_x_valid"}, {15'b0, x_valid}, 16'h0000);
        chk({tag, "_x_out"}, x_out, 16'h0000);
        chk({tag, "_rd_valid"}, {15'b0, rd_valid}, 16'h0000);
        chk({tag, "_rd_data"}, rd_data, 16'h0000);
        chk({tag, "_alpha"}, alpha, 16'd8192);
        chk({tag, "_bypass"}, {15'b0, bypass}, 16'h0000);
        chk({tag, "_filt_en"}, {15'b0, filt_en}, 16'h0001);
        chk({tag, "_err"}, {15'b0, err}, 16'h0000);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("por");
        #2 reset = 1'b1;
        repeat (5) @(posedge clk);
        check_static();

        // Write alpha then read it back
        frame_q = '{16'h2000, 16'h1000};
        send_frame(1'b0);
        frame_q = '{16'h3000};
        send_frame(1'b0);
        check_static();

        // Counted stream: fourth sample dropped, then counter readback
        frame_q = '{16'h1003, 16'h0011, 16'h0022, 16'h0033, 16'h0044};
        send_frame(1'b0);
        frame_q = '{16'h3200};
        send_frame(1'b0);

        // Unbounded stream closed on the same cycle as the last word
        frame_q = '{16'h1000, 16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505};
        send_frame(1'b1);
        frame_q = '{16'h3200};
        send_frame(1'b0);

        // Illegal opcode, status read-and-clear, aborted write
        frame_q = '{16'h7000};
        send_frame(1'b0);
        check_static();
        frame_q = '{16'h3300};
        send_frame(1'b0);
        check_static();
        frame_q = '{16'h2100};
        send_frame(1'b0);
        check_static();

        // Randomised frames
        for (int f = 0; f < 40; f++) begin
            logic [3:0] op;
            logic [3:0] addr;
            logic [7:0] cf;
            int         len;
            int         r;
            r    = $urandom_range(0, 3);
            op   = (r < 3) ? 4'(r + 1) : 4'($urandom_range(4, 16));
            addr = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
            cf   = 8'($urandom_range(0, 5));
            len  = (op == 4'd1) ? $urandom_range(0, 7) : $urandom_range(0, 2);
            frame_q = {};
            frame_q.push_back({op, addr, cf});
            for (int k = 0; k < len; k++) frame_q.push_back(16'($urandom));
            send_frame(1'($urandom_range(0, 1)));
            check_static();
        end

        // Asynchronous reset in the middle of a stream frame
        frame_q = '{16'h2000, 16'h1234};
        send_frame(1'b0);
        frame_q = '{16'h3000};
        send_frame(1'b0);
        frame_q = '{16'h7000};
        send_frame(1'b0);
        @(posedge clk); #1 sel_n = 1'b0;
        @(posedge clk); #1 word_in = 16'h1000; word_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1 word_in = 16'hA5A0 + 16'(k); word_valid = 1'b1;
            exp_x.push_back('{word_in, cyc + 1});
            cnt_m = cnt_m + 16'd1;
        end
        @(posedge clk); #1 word_valid = 1'b0;
        @(negedge clk); #1 reset = 1'b0;
        #1 check_reset_outputs("async");
        alpha_m = 16'd8192;
        ctrl_m  = 2'b10;
        cnt_m   = '0;
        err_m   = 1'b0;
        sel_n   = 1'b1;
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        frame_q = '{16'h3200};
        send_frame(1'b0);
        frame_q = '{16'h1002, 16'h0F0F, 16'hF0F0};
        send_frame(1'b0);
        check_static();

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("exp_x_drained", 16'(exp_x.size()), 16'h0000);
        chk("exp_rd_drained", 16'(exp_rd.size()), 16'h0000);
        chk("exp_w_drained", 16'(exp_w.size()), 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
